// File: rtl/comb_multiplier_fp32.sv
// Single-cycle IEEE-754 binary32 multiplier: full product, normalization and
// round-to-nearest-even in one combinational pass, result registered once.
module comb_multiplier_fp32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] output_z
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0]        op       [2];
    logic [23:0]        mant     [2];
    logic signed [10:0] exp_unb  [2];
    logic               is_nan   [2];
    logic               is_inf   [2];
    logic               is_zero  [2];

    assign op[0] = a;
    assign op[1] = b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign is_nan[gi]  = (op[gi][30:23] == 8'hFF) && (op[gi][22:0] != 23'd0);
            assign is_inf[gi]  = (op[gi][30:23] == 8'hFF) && (op[gi][22:0] == 23'd0);
            assign is_zero[gi] = (op[gi][30:0] == 31'd0);
            // Subnormals keep a zero hidden bit and share the minimum exponent.
            assign mant[gi]    = {op[gi][30:23] != 8'd0, op[gi][22:0]};
            assign exp_unb[gi] = (op[gi][30:23] == 8'd0) ? -11'sd126
                               : $signed({3'b000, op[gi][30:23]}) - 11'sd127;
        end
    endgenerate

    logic               sign;
    logic [47:0]        prod;
    logic [5:0]         lz;
    logic [47:0]        norm;
    logic signed [10:0] biased;
    logic               is_sub;
    logic signed [10:0] sub_dist;
    logic [5:0]         sh;
    logic [9:0]         exp_pre;
    logic [95:0]        wide;
    logic [23:0]        mant_t;
    logic               guard;
    logic               rnd;
    logic               sticky;
    logic               inc;
    logic [24:0]        mant_r;
    logic [9:0]         exp_fin;
    logic [22:0]        frac_fin;
    logic [31:0]        z_next;

    assign sign = a[31] ^ b[31];
    assign prod = {24'd0, mant[0]} * {24'd0, mant[1]};

    // Highest set bit wins, so lz is the distance of the leading one from bit 47.
    always_comb begin
        lz = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) lz = 6'(47 - i);
        end
    end

    assign norm   = prod << lz;
    // Leading one at bit 47 means value = 1.x * 2^(ea+eb+1); add the 127 bias.
    assign biased = exp_unb[0] + exp_unb[1] + 11'sd128 - $signed({5'd0, lz});

    always_comb begin
        is_sub   = (biased <= 11'sd0);
        sub_dist = 11'sd1 - biased;
        sh       = 6'd0;
        exp_pre  = biased[9:0];
        if (is_sub) begin
            exp_pre = 10'd0;
            sh      = (sub_dist > 11'sd63) ? 6'd63 : sub_dist[5:0];
        end
    end

    // Denormalizing shift into a wide window so every discarded bit lands in sticky.
    assign wide   = {norm, 48'd0} >> sh;
    assign mant_t = wide[95:72];
    assign guard  = wide[71];
    assign rnd    = wide[70];
    assign sticky = |wide[69:0];
    assign inc    = guard & (rnd | sticky | mant_t[0]);
    assign mant_r = {1'b0, mant_t} + {24'd0, inc};

    always_comb begin
        exp_fin  = exp_pre;
        frac_fin = mant_r[22:0];
        if (is_sub) begin
            // Rounding up into bit 23 turns the subnormal into the smallest normal.
            exp_fin = {9'd0, mant_r[23]};
        end else if (mant_r[24]) begin
            exp_fin  = exp_pre + 10'd1;
            frac_fin = mant_r[23:1];
        end
    end

    always_comb begin
        z_next = {sign, exp_fin[7:0], frac_fin};
        if (is_nan[0] || is_nan[1]) begin
            z_next = QNAN;
        end else if ((is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0])) begin
            z_next = QNAN;
        end else if (is_inf[0] || is_inf[1]) begin
            z_next = {sign, 8'hFF, 23'd0};
        end else if (is_zero[0] || is_zero[1]) begin
            z_next = {sign, 31'd0};
        end else if (!is_sub && (exp_fin >= 10'd255)) begin
            z_next = {sign, 8'hFF, 23'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) output_z <= 32'h0000_0000;
        else     output_z <= z_next;
    end

endmodule

// File: tb/tb_comb_multiplier_fp32.sv
// Bench for comb_multiplier_fp32: reset, directed vector table, mid-stream reset,
// and random operands checked against a real-arithmetic rounding model.
module tb_comb_multiplier_fp32;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] output_z;

    int tests;
    int fails;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;

    vec_t vecs[$];

    comb_multiplier_fp32 dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .output_z (output_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real pow2(int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real mag(logic [31:0] x);
        if (x[30:23] == 8'd0) return real'(x[22:0]) * pow2(-149);
        return (8388608.0 + real'(x[22:0])) * pow2(int'(x[30:23]) - 150);
    endfunction

    // Exact product in real arithmetic, then rounded to the binary32 grid.
    function automatic logic [31:0] ref_mul(logic [31:0] x, logic [31:0] y);
        logic s;
        logic xnan, ynan, xinf, yinf, xzero, yzero;
        real  v, m, q, n, fl, rem;
        int   e, ee, fli;
        s     = x[31] ^ y[31];
        xnan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        ynan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xinf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yinf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xzero = (x[30:0] == 31'd0);
        yzero = (y[30:0] == 31'd0);
        if (xnan || ynan) return QNAN;
        if ((xinf && yzero) || (yinf && xzero)) return QNAN;
        if (xinf || yinf) return {s, 8'hFF, 23'd0};
        if (xzero || yzero) return {s, 31'd0};
        v = mag(x) * mag(y);
        m = v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        ee  = (e < -126) ? -126 : e;
        q   = pow2(ee - 23);
        n   = v / q;
        fl  = $floor(n);
        rem = n - fl;
        fli = $rtoi(fl);
        if (rem > 0.5 || (rem == 0.5 && fli[0])) fli++;
        if (e < -126) return {s, 31'(fli)};
        if (fli == (1 << 24)) begin
            fli = 1 << 23;
            e++;
        end
        if (e > 127) return {s, 8'hFF, 23'd0};
        return {s, 8'(e + 127), 23'(fli - (1 << 23))};
    endfunction

    function automatic logic [31:0] rand_op();
        int unsigned sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        if (sel <= 2)       e = 8'd0;
        else if (sel == 3) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = 23'd0;
        end
        else if (sel == 4)  e = 8'($urandom_range(1, 24));
        else if (sel == 5)  e = 8'($urandom_range(230, 254));
        else if (sel == 6)  e = 8'($urandom_range(100, 154));
        else                e = 8'($urandom_range(1, 254));
        if (sel == 7) f = 23'd0;
        return {1'($urandom), e, f};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s a=%08h b=%08h got=%08h want=%08h", name, a, b, got, want);
        end else begin
            $display("[TB] %s a=%08h b=%08h z=%08h ok", name, a, b, got);
        end
    endtask

    initial begin
        logic [31:0] want;
        tests = 0;
        fails = 0;

        vecs.push_back('{"mul_5x3",       32'h40A00000, 32'h40400000, 32'h41700000});
        vecs.push_back('{"mul_m5x7",      32'hC0A00000, 32'h40E00000, 32'hC20C0000});
        vecs.push_back('{"zero_x_zero",   32'h00000000, 32'h00000000, 32'h00000000});
        vecs.push_back('{"inf_x_zero",    32'h7F800000, 32'h00000000, 32'h7FC00000});
        vecs.push_back('{"zero_x_inf",    32'h00000000, 32'hFF800000, 32'h7FC00000});
        vecs.push_back('{"ninf_x_2",      32'hFF800000, 32'h40000000, 32'hFF800000});
        vecs.push_back('{"qnan_x_1",      32'h7FC00000, 32'h3F800000, 32'h7FC00000});
        vecs.push_back('{"snan_x_1",      32'h3F800000, 32'hFF800001, 32'h7FC00000});
        vecs.push_back('{"nzero_x_1",     32'h80000000, 32'h3F800000, 32'h80000000});
        vecs.push_back('{"overflow",      32'h7F7FFFFF, 32'h40000000, 32'h7F800000});
        vecs.push_back('{"rne_round",     32'h3F800001, 32'h3F800001, 32'h3F800002});
        vecs.push_back('{"mant_renorm",   32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE});
        vecs.push_back('{"sub_x_2",       32'h00000001, 32'h40000000, 32'h00000002});
        vecs.push_back('{"grad_uflow",    32'h00800000, 32'h3F000000, 32'h00400000});
        vecs.push_back('{"tie_to_even",   32'h00000001, 32'h3F000000, 32'h00000000});
        vecs.push_back('{"round_up_min",  32'h00000001, 32'h3F400000, 32'h00000001});
        vecs.push_back('{"carry_to_norm", 32'h00FFFFFF, 32'h3F000000, 32'h00800000});
        vecs.push_back('{"sub_x_sub",     32'h00400000, 32'h00400000, 32'h00000000});

        rst = 1'b1;
        a   = 32'h40A00000;
        b   = 32'h40400000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_hold", output_z, 32'h00000000);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("reset_release", output_z, 32'h41700000);

        // Operands change every cycle; each result is checked one edge later.
        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            @(posedge clk);
            #1 check(vecs[i].name, output_z, vecs[i].z);
        end

        @(negedge clk);
        a   = 32'hC0A00000;
        b   = 32'h40E00000;
        rst = 1'b1;
        @(posedge clk);
        #1 check("midrst_discard", output_z, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        a   = 32'h3F800001;
        b   = 32'h3F800001;
        @(posedge clk);
        #1 check("midrst_first", output_z, 32'h3F800002);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a    = rand_op();
            b    = rand_op();
            want = ref_mul(a, b);
            @(posedge clk);
            #1 check($sformatf("rand_%0d", i), output_z, want);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
